// File: rtl/aes_pkg.sv
// Shared AES-128 AddRoundKey sequencing types: round/byte indices, pipeline entry and FSM states.
package aes_pkg;

    localparam int AES_ROUNDS       = 10;
    localparam int AES_BYTES        = 16;
    localparam int AES_LAST_KEY_LAT = 2;

    typedef logic [3:0] round_t;
    typedef logic [3:0] byte_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // One tagged byte travelling down the key-latency delay line.
    typedef struct packed {
        logic      valid;
        round_t    round;
        byte_idx_t idx;
        logic [7:0] data;
    } ark_entry_t;

endpackage

// File: rtl/ark_delay_line.sv
// Tagged shift line that delays each state byte to meet its key byte; normal rounds tap
// stage 1, the final round taps stage LAST_KEY_LAT, and the outputs hold when nothing is selected.
module ark_delay_line
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS   = AES_ROUNDS,
    parameter int LAST_KEY_LAT = AES_LAST_KEY_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  round_t     push_round,
    input  byte_idx_t  push_idx,
    input  logic [7:0] push_data,
    output logic       out_valid,
    output round_t     out_sel,
    output byte_idx_t  out_idx,
    output logic [7:0] out_data,
    output logic       pending
);

    localparam int DEPTH = LAST_KEY_LAT + 1;

    ark_entry_t stage_q [DEPTH];
    ark_entry_t stage_d [DEPTH];
    round_t     hold_sel_q, hold_sel_d;
    logic [7:0] hold_data_q, hold_data_d;
    ark_entry_t tap;

    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        stage_d[0] = '{valid: push, round: push_round, idx: push_idx, data: push_data};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end

        tap = '0;
        if (stage_q[1].valid && stage_q[1].round != round_t'(NUM_ROUNDS)) begin
            tap = stage_q[1];
        end else if (stage_q[LAST_KEY_LAT].valid &&
                     stage_q[LAST_KEY_LAT].round == round_t'(NUM_ROUNDS)) begin
            tap = stage_q[LAST_KEY_LAT];
        end
        hold_sel_d  = tap.valid ? tap.round : hold_sel_q;
        hold_data_d = tap.valid ? tap.data  : hold_data_q;

        // Entries that will still emit after this cycle; the last stage is emitting now.
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage_q[i].valid;
        end
    end

    // NOTE: the line is only a few entries deep, so every entry is reset; a reset
    // mid-block must discard in-flight bytes rather than let stale valids emerge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            hold_sel_q  <= '0;
            hold_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            hold_sel_q  <= hold_sel_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign out_valid = tap.valid;
    assign out_idx   = tap.idx;
    assign out_sel   = tap.valid ? tap.round : hold_sel_q;
    assign out_data  = tap.valid ? tap.data  : hold_data_q;

endmodule

// File: rtl/ark_round_sequencer.sv
// Byte-serial AddRoundKey sequencer for one AES-128 block (11 rounds x 16 bytes).
// Optional abort input enabled by defining ARK_SEQ_ABORT_EN.
module ark_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS      = AES_ROUNDS,
    parameter int BYTES_PER_ROUND = AES_BYTES,
    parameter int LAST_KEY_LAT    = AES_LAST_KEY_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
`ifdef ARK_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [3:0] ark_addr,
    output logic [3:0] ark_sel,
    output logic [7:0] ark_data,
    output logic       ark_valid,
    output logic       round_done,
    output logic       busy,
    output logic       done
);

    seq_state_t state_q, state_d;
    round_t     round_q, round_d;
    byte_idx_t  byte_q, byte_d;
    byte_idx_t  addr_q, addr_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       abort_w;
    logic       xfer;
    logic       pending;
    byte_idx_t  out_idx;

`ifdef ARK_SEQ_ABORT_EN
    assign abort_w = abort & (state_q == RUN || state_q == DRAIN);
`else
    assign abort_w = 1'b0;
`endif

    // Abort must block the handshake in the very cycle it is raised.
    assign in_ready = in_ready_q & ~abort_w;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        byte_d  = byte_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    round_d = '0;
                    byte_d  = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (byte_q == byte_idx_t'(BYTES_PER_ROUND - 1)) begin
                        byte_d = '0;
                        if (round_q == round_t'(NUM_ROUNDS)) begin
                            state_d = DRAIN;
                        end else begin
                            round_d = round_q + round_t'(1);
                        end
                    end else begin
                        byte_d = byte_q + byte_idx_t'(1);
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_w) begin
            state_d = IDLE;
        end
        if (xfer) begin
            addr_d = byte_q;
        end

        in_ready_d = (state_d == RUN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            byte_q     <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    ark_delay_line #(
        .NUM_ROUNDS   (NUM_ROUNDS),
        .LAST_KEY_LAT (LAST_KEY_LAT)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort_w),
        .push       (xfer),
        .push_round (round_q),
        .push_idx   (byte_q),
        .push_data  (in_data),
        .out_valid  (ark_valid),
        .out_sel    (ark_sel),
        .out_idx    (out_idx),
        .out_data   (ark_data),
        .pending    (pending)
    );

    assign round_done = ark_valid && (out_idx == byte_idx_t'(BYTES_PER_ROUND - 1));
    assign ark_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ark_round_sequencer.sv
// Randomized self-checking bench for ark_round_sequencer against a transaction-level model.
module tb_ark_round_sequencer;

    localparam int TOTAL = 176;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] ark_addr;
    logic [3:0] ark_sel;
    logic [7:0] ark_data;
    logic       ark_valid;
    logic       round_done;
    logic       busy;
    logic       done;
`ifdef ARK_SEQ_ABORT_EN
    logic       abort;
`endif

    ark_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
`ifdef ARK_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ark_addr   (ark_addr),
        .ark_sel    (ark_sel),
        .ark_data   (ark_data),
        .ark_valid  (ark_valid),
        .round_done (round_done),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: accepted byte n belongs to round n/16, byte n%16, and surfaces
    // 2 cycles after acceptance (3 for the final round); done follows 4 cycles after the last byte.
    typedef struct {
        int         due;
        int         round;
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    bit         active;
    int         s_cyc;
    int         n_acc;
    int         done_cyc;
    int         exp_addr;
    int         last_sel;
    int         last_data;
    int         rd_cnt;
    int         done_cnt;
    logic [7:0] blk [TOTAL];
    logic [7:0] key0 [16];
    logic [7:0] r1 [16];

    task automatic model_reset();
        q.delete();
        active    = 0;
        n_acc     = 0;
        exp_addr  = 0;
        last_sel  = 0;
        last_data = 0;
    endtask

    task automatic check_outputs();
        bit   run;
        bit   dn;
        exp_t e;
        run = active && (cyc > s_cyc);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("ark_valid", ark_valid, 1);
            check("ark_sel", ark_sel, e.round);
            check("ark_data", ark_data, e.data);
            check("round_done", round_done, (e.idx == 15));
            if (e.round == 0) check("fips_xor", ark_data ^ key0[e.idx], r1[e.idx]);
            last_sel  = e.round;
            last_data = e.data;
        end else begin
            check("ark_valid_idle", ark_valid, 0);
            check("round_done_idle", round_done, 0);
            check("ark_sel_hold", ark_sel, last_sel);
            check("ark_data_hold", ark_data, last_data);
        end
        if (round_done === 1'b1) rd_cnt++;
        if (done === 1'b1) done_cnt++;
        check("in_ready", in_ready, run && (n_acc < TOTAL));
        check("busy", busy, run);
        dn = run && (n_acc == TOTAL) && (cyc == done_cyc);
        check("done", done, dn);
        check("ark_addr", ark_addr, exp_addr);
        if (dn) active = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic a);
        bit run;
        int r;
        int b;
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_data  = d;
        start    = s;
`ifdef ARK_SEQ_ABORT_EN
        abort    = a;
`endif
        #1;
        run = active && (cyc > s_cyc);
`ifdef ARK_SEQ_ABORT_EN
        if (a && run) begin
            check("abort_in_ready", in_ready, 0);
            q.delete();
            active = 0;
            return;
        end
`endif
        if (s && !active) begin
            active = 1;
            s_cyc  = cyc;
            n_acc  = 0;
        end
        if (v && run && n_acc < TOTAL) begin
            r = n_acc / 16;
            b = n_acc % 16;
            q.push_back('{due: cyc + ((r == 10) ? 3 : 2), round: r, idx: b, data: d});
            exp_addr = b;
            n_acc++;
            if (n_acc == TOTAL) done_cyc = cyc + 4;
        end
    endtask

    task automatic reset_now();
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        start    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_ark_valid", ark_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_round_done", round_done, 0);
        check("rst_ark_addr", ark_addr, 0);
        check("rst_ark_sel", ark_sel, 0);
        check("rst_ark_data", ark_data, 0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // gap_pct: chance of in_valid low; restart_at/rst_at/abort_at: accepted-byte count that triggers the event.
    task automatic run_block(input int gap_pct, input int restart_at, input int rst_at, input int abort_at);
        int  guard;
        bit  v;
        bit  restarted;
        logic [127:0] pt;
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        for (int i = 0; i < TOTAL; i++) begin
            blk[i] = (i < 16) ? pt[127 - 8*i -: 8] : 8'($urandom_range(255));
        end
        rd_cnt    = 0;
        done_cnt  = 0;
        restarted = 0;
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        guard = 0;
        while (n_acc < TOTAL && guard < 3000) begin
            guard++;
            if (n_acc == rst_at) begin
                reset_now();
                return;
            end
            if (n_acc == abort_at) begin
                step(1'b1, blk[n_acc], 1'b0, 1'b1);
                repeat (6) step(1'b0, 8'h00, 1'b0, 1'b0);
                check("abort_no_done", done_cnt, 0);
                return;
            end
            v = ($urandom_range(99) >= gap_pct);
            if (!restarted && n_acc == restart_at) begin
                restarted = 1;
                step(v, v ? blk[n_acc] : 8'($urandom_range(255)), 1'b1, 1'b0);
            end else begin
                step(v, v ? blk[n_acc] : 8'($urandom_range(255)), 1'b0, 1'b0);
            end
        end
        if (n_acc < TOTAL) check("accept_timeout", n_acc, TOTAL);
        guard = 0;
        while (active && guard < 20) begin
            guard++;
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        if (active) check("done_timeout", 0, 1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("round_done_count", rd_cnt, 11);
        check("done_count", done_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [127:0] kv;
        logic [127:0] sv;
        kv = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        sv = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        for (int i = 0; i < 16; i++) begin
            key0[i] = kv[127 - 8*i -: 8];
            r1[i]   = sv[127 - 8*i -: 8];
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef ARK_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        model_reset();
        s_cyc = 0;
        #1;
        check("reset_ark_valid", ark_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ark_addr", ark_addr, 0);
        check("reset_ark_sel", ark_sel, 0);
        check("reset_ark_data", ark_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_block(0, -1, -1, -1);
        run_block(50, 3*16 + 5, -1, -1);
        run_block(30, -1, 5*16 + 7, -1);
        run_block(50, -1, -1, -1);
`ifdef ARK_SEQ_ABORT_EN
        run_block(20, -1, -1, 4*16 + 2);
        run_block(0, -1, -1, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ark_round_sequencer.md
Name: ark_round_sequencer

Overview:
- Sequences the AddRoundKey state datapath for one AES-128 block: 11 rounds × 16 bytes, fed as a byte-serial stream.
- Accepts bytes over a valid/ready handshake and drives the datapath's key-ROM address, round select and data input.
- Delays each byte so it meets its key byte. Key latency is 1 cycle for rounds 0-9 and 2 cycles for round 10, because the round-10 key has an extra register.
- Emits a valid strobe aligned to the XOR result, plus per-round and per-block completion pulses.

Parameters:
- NUM_ROUNDS, 10, index of the final round; selects 0..NUM_ROUNDS.
- BYTES_PER_ROUND, 16, bytes per round; the address counter wraps at this value.
- LAST_KEY_LAT, 2, key read latency of the final round, in cycles after address issue.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a block. Honoured only in IDLE.
- in_valid  in  1  in_data holds a valid state byte.
- in_data  in  8  state byte: round r, byte index b, in order.
- in_ready  out  1  sequencer accepts a byte this cycle.
- ark_addr  out  4  key byte index; drives the datapath addr_in.
- ark_sel  out  4  round select aligned with ark_data; drives sel.
- ark_data  out  8  delayed state byte; drives data_in.
- ark_valid  out  1  the XOR output of the datapath is valid this cycle.
- round_done  out  1  pulse with the ark_valid of byte 15 of each round.
- busy  out  1  high from start accept until the done pulse, inclusive.
- done  out  1  one-cycle pulse, the cycle after the last round-10 byte is valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; round=0, byte=0; pipeline valids cleared. in_ready, ark_valid, round_done, busy, done = 0; ark_addr, ark_sel, ark_data = 0.
- FSM states:
  - IDLE: in_ready=0. start=1 → RUN with round=0, byte=0, busy=1.
  - RUN: in_ready=1. A transfer at in_valid&in_ready does byte++.
    - byte==15 on transfer: byte→0, round++.
    - Transfer of round NUM_ROUNDS byte 15 → DRAIN.
    - in_valid low stalls the sequencer; no bubbles are inserted and pipeline entries still advance.
  - DRAIN: in_ready=0. Waits until the pipeline is empty, then → DONE.
  - DONE: done=1 for one cycle; busy still 1. Next cycle → IDLE, busy=0.
- Timing for a transfer at cycle T:
  - ark_addr=b is registered at T+1.
  - Rounds 0-9: ark_data, ark_sel=r and ark_valid appear at T+2.
  - Round 10: the same appear at T+1+LAST_KEY_LAT = T+3.
- Pipeline:
  - A 3-entry shift line of {valid, round, byte, data}.
  - The output mux takes stage 2 when round<NUM_ROUNDS and stage 3 when round==NUM_ROUNDS.
  - When no entry is valid at the selected stage, ark_valid=0 and ark_sel/ark_data hold their last values.
  - Back-to-back round 9 → round 10 transfers create a one-cycle output gap, never a collision.
  - A collision is impossible because round 0 of the next block cannot enter until after DONE.
- ark_addr is registered and updates only on a transfer; it holds otherwise.
- Wrap: the byte counter is 4 bits and wraps 15→0 with round increment. round never exceeds NUM_ROUNDS.
- start while busy is ignored, with no effect on any state.
- Reset mid-operation: everything returns to reset values immediately. In-flight bytes are discarded and no done is issued.
- start and reset release in the same cycle: start is ignored, because reset has priority.

Optional Feature:
- Macro: ARK_SEQ_ABORT_EN.
- With the macro defined: an extra input port abort (1 bit). abort=1 in RUN or DRAIN:
  - clears all pipeline valids that cycle, so ark_valid=0 from the next cycle;
  - forces in_ready=0 in the same cycle;
  - moves to IDLE next cycle, with busy=0 and no done or round_done.
- abort in IDLE or DONE has no effect.
- Without the macro: no abort port; the block always runs to completion.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_ROUNDS=10, AES_BYTES=16, AES_LAST_KEY_LAT=2;
  - a typedef for the round index (4 bits) and the byte index (4 bits);
  - the FSM state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: ark_delay_line, the tagged 3-stage shift line with its latency-select output mux.

Test Plan:
- FIPS-197 vector, key 2b7e1516..., plaintext 3243f6a8...:
  - stream all 176 bytes with in_valid held high;
  - the first ark_valid at cycle T+2 must give datapath output 0x19;
  - 11 round_done pulses, one done pulse, and busy low after done.
- Random in_valid gaps (50% duty) over a full block → identical output byte sequence; ark_addr tracks the accepted byte index; no duplicated or lost bytes.
- Round 9 byte 15 accepted at cycle T, round 10 byte 0 at T+1 → outputs at T+2 and T+4, with ark_sel 9 then 10 and ark_valid low at T+3.
- rst low at round 5 byte 7 → all outputs 0 immediately. A new start after release runs a full clean block starting at round 0, byte 0.
- start pulsed again at round 3 → ignored: round count, ark_sel sequence and done timing unchanged.
- With ARK_SEQ_ABORT_EN, abort at round 4 byte 2 → in_ready=0 that cycle, ark_valid=0 from the next cycle, IDLE the following cycle, no done.
